// File: rtl/spike_dec_pkg.sv
// Shared types and helpers for the spike rate decoder.
// Holds the FSM state enum, default parameter values and a saturating add.
package spike_dec_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    localparam int WIN_LOG2_DEF = 8;
    localparam int CNT_W_DEF    = 8;
    localparam int ISI_W_DEF    = 8;

    // a + b clamped to max; callers size the result back to their width
    function automatic logic [31:0] sat_add(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] max
    );
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[31:0];
    endfunction

endpackage

// File: rtl/spike_rate_decoder_edge_counter.sv
// Rising-edge detector on the spike input plus a saturating edge counter.
// Ports: clk, rst, spike, clr, cnt_en in; rise, cnt, cnt_nxt (cnt + rise, saturated) out.
module spike_edge_counter
    import spike_dec_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             spike,
    input  logic             clr,
    input  logic             cnt_en,
    output logic             rise,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_nxt
);

    localparam logic [31:0] CNT_MAX = 32'((64'(1) << CNT_W) - 64'(1));

    logic spike_q;

    // a spike held high across many cycles contributes a single edge
    assign rise    = spike & ~spike_q;
    assign cnt_nxt = CNT_W'(sat_add(32'(cnt), {31'd0, rise}, CNT_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            spike_q <= 1'b0;
            cnt     <= '0;
        end else begin
            spike_q <= spike;
            if (clr)
                cnt <= '0;
            else if (cnt_en)
                cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Counts spike rising edges per 2**WIN_LOG2-cycle window and hands the rate out on valid/ready.
// Ports: clk, rst, en, spike, rate_ready in; rate_out, rate_valid, overrun, busy, isi_out out.
// Optional inter-spike-interval measurement is built when SPIKE_DEC_ISI_EN is defined.
module spike_rate_decoder
    import spike_dec_pkg::*;
#(
    parameter int WIN_LOG2 = WIN_LOG2_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int ISI_W    = ISI_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             spike,
    output logic [CNT_W-1:0] rate_out,
    output logic             rate_valid,
    input  logic             rate_ready,
    output logic             overrun,
    output logic             busy,
    output logic [ISI_W-1:0] isi_out
);

    state_t              state;
    logic [WIN_LOG2-1:0] win_cnt;
    logic                rise;
    logic [CNT_W-1:0]    spk_cnt;
    logic [CNT_W-1:0]    spk_nxt;
    logic                counting;
    logic                term;
    logic                res_pend;
    logic [CNT_W-1:0]    res_cnt;

    assign counting = (state == COUNT) && en;
    assign term     = counting && (win_cnt == '1);
    assign busy     = (state == COUNT);

    spike_edge_counter #(
        .CNT_W (CNT_W)
    ) u_edge (
        .clk     (clk),
        .rst     (rst),
        .spike   (spike),
        .clr     (!counting || term),
        .cnt_en  (counting),
        .rise    (rise),
        .cnt     (spk_cnt),
        .cnt_nxt (spk_nxt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            win_cnt    <= '0;
            res_pend   <= 1'b0;
            res_cnt    <= '0;
            rate_out   <= '0;
            rate_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    win_cnt <= '0;
                    if (en)
                        state <= COUNT;
                end
                COUNT: begin
                    if (!en) begin
                        state   <= IDLE;
                        win_cnt <= '0;
                    end else begin
                        // wraps to 0 after the terminal cycle: windows run back to back
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // window result is staged one cycle before it meets the handshake
            res_pend <= term;
            if (term)
                res_cnt <= spk_nxt;

            if (res_pend) begin
                if (!rate_valid || rate_ready) begin
                    rate_out   <= res_cnt;
                    rate_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rate_valid && rate_ready) begin
                rate_valid <= 1'b0;
            end

            if (!en)
                overrun <= 1'b0;
        end
    end

`ifdef SPIKE_DEC_ISI_EN
    localparam logic [31:0] ISI_MAX = 32'((64'(1) << ISI_W) - 64'(1));

    logic [ISI_W-1:0] isi_cnt;
    logic [ISI_W-1:0] isi_nxt;
    logic             prior;

    assign isi_nxt = ISI_W'(sat_add(32'(isi_cnt), 32'd1, ISI_MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            isi_cnt <= '0;
            prior   <= 1'b0;
            isi_out <= '0;
        end else if (counting) begin
            if (rise) begin
                if (prior)
                    isi_out <= isi_nxt;
                isi_cnt <= '0;
                prior   <= 1'b1;
            end else begin
                isi_cnt <= isi_nxt;
            end
        end else begin
            // leaving COUNT forgets the previous edge; isi_out keeps its value
            isi_cnt <= '0;
            prior   <= 1'b0;
        end
    end
`else
    logic unused_rise;
    assign unused_rise = rise;
    assign isi_out     = '0;
`endif

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Self-checking bench for spike_rate_decoder (WIN_LOG2=4, CNT_W=8 and CNT_W=3 copies).
// Directed scenarios followed by random traffic, compared against a window-level model.
module tb_spike_rate_decoder;

    localparam int WIN = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       spike = 1'b0;
    logic       rdy = 1'b0;

    logic [7:0] rate_out;
    logic       rate_valid;
    logic       overrun;
    logic       busy;
    logic [7:0] isi_out;

    logic [2:0] rate3;
    logic       valid3;
    logic       ovr3;
    logic       busy3;
    logic [7:0] isi3;

    always #5 clk = ~clk;

    spike_rate_decoder #(
        .WIN_LOG2 (4),
        .CNT_W    (8),
        .ISI_W    (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .spike      (spike),
        .rate_out   (rate_out),
        .rate_valid (rate_valid),
        .rate_ready (rdy),
        .overrun    (overrun),
        .busy       (busy),
        .isi_out    (isi_out)
    );

    spike_rate_decoder #(
        .WIN_LOG2 (4),
        .CNT_W    (3),
        .ISI_W    (8)
    ) dut3 (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .spike      (spike),
        .rate_out   (rate3),
        .rate_valid (valid3),
        .rate_ready (rdy),
        .overrun    (ovr3),
        .busy       (busy3),
        .isi_out    (isi3)
    );

    int nvec = 0;
    int nerr = 0;

    // reference model state: window sample list, pending result, output view
    bit m_busy;
    bit q[$];
    bit win_prev;
    bit last_s;
    bit pend;
    int pend_cnt;
    bit e_valid;
    int e_rate8;
    int e_rate3;
    bit e_ovr;
    int cyc;
    int last_edge_cyc;
    bit have_prior;
    int e_isi;

    function automatic int min_i(int a, int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_busy = 0; q.delete(); win_prev = 0; last_s = 0;
        pend = 0; pend_cnt = 0; e_valid = 0; e_rate8 = 0; e_rate3 = 0;
        e_ovr = 0; have_prior = 0; e_isi = 0;
    endtask

    task automatic model_edge();
        int n;
        bit p;
        bit old_valid;
        old_valid = e_valid;
        if (pend) begin
            if (!old_valid || rdy) begin
                e_rate8 = min_i(pend_cnt, 255);
                e_rate3 = min_i(pend_cnt, 7);
                e_valid = 1;
            end else begin
                e_ovr = 1;
            end
            pend = 0;
        end else if (old_valid && rdy) begin
            e_valid = 0;
        end
        if (!en) e_ovr = 0;

        if (m_busy) begin
            if (!en) begin
                m_busy = 0;
                q.delete();
                have_prior = 0;
            end else begin
                if (spike && !last_s) begin
                    if (have_prior) e_isi = min_i(cyc - last_edge_cyc, 255);
                    last_edge_cyc = cyc;
                    have_prior = 1;
                end
                q.push_back(spike);
                if (q.size() == WIN) begin
                    n = 0;
                    p = win_prev;
                    foreach (q[i]) begin
                        if (q[i] && !p) n++;
                        p = q[i];
                    end
                    pend = 1;
                    pend_cnt = n;
                    win_prev = q[WIN-1];
                    q.delete();
                end
            end
        end else if (en) begin
            m_busy = 1;
            q.delete();
            win_prev = spike;
        end
        last_s = spike;
        cyc++;
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("rate_out", 32'(rate_out), 32'(e_rate8));
        chk("rate_valid", 32'(rate_valid), 32'(e_valid));
        chk("overrun", 32'(overrun), 32'(e_ovr));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("rate_out_w3", 32'(rate3), 32'(e_rate3));
`ifdef SPIKE_DEC_ISI_EN
        chk("isi_out", 32'(isi_out), 32'(e_isi));
`else
        chk("isi_out", 32'(isi_out), 32'd0);
`endif
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        check_all();
    endtask

    task automatic steps(int n);
        repeat (n) step();
    endtask

    initial begin
        model_reset();
        cyc = 0;
        last_edge_cyc = 0;

        // reset
        #1 rst = 1;
        #1 check_all();
        steps(2);
        rst = 0;

        // spikes every 4 cycles, ready high
        rdy = 1; en = 1; spike = 0;
        step();
        for (int k = 0; k < 40; k++) begin
            spike = (k % 4 == 0);
            step();
            if (k == 15) chk("lat_not_yet", 32'(rate_valid), 32'd0);
            if (k == 16) begin
                chk("lat_valid", 32'(rate_valid), 32'd1);
                chk("lat_rate4", 32'(rate_out), 32'd4);
            end
        end

        // spike held high across two windows
        en = 0; spike = 0;
        steps(2);
        en = 1;
        step();
        spike = 1;
        for (int k = 1; k <= 33; k++) begin
            step();
            if (k == 17) chk("held_rate1", 32'(rate_out), 32'd1);
            if (k == 33) begin
                chk("held_valid", 32'(rate_valid), 32'd1);
                chk("held_rate0", 32'(rate_out), 32'd0);
            end
        end

        // consumer stalled for three windows
        en = 0; rdy = 1; spike = 0;
        step();
        en = 1; rdy = 0;
        step();
        for (int k = 1; k <= 48; k++) begin
            spike = ($urandom_range(0, 2) == 0);
            step();
            if (k == 17) chk("stall_ovr_w1", 32'(overrun), 32'd0);
            if (k == 33) chk("stall_ovr_w2", 32'(overrun), 32'd1);
        end
        en = 0;
        step();
        chk("en0_clr_ovr", 32'(overrun), 32'd0);
        chk("en0_keep_valid", 32'(rate_valid), 32'd1);
        rdy = 1;
        step();
        chk("drain_valid", 32'(rate_valid), 32'd0);

        // toggling spike: 8 edges saturate the 3-bit copy
        en = 0; spike = 0;
        step();
        en = 1;
        step();
        for (int k = 1; k <= 17; k++) begin
            spike = k[0];
            step();
        end
        chk("sat_rate3", 32'(rate3), 32'd7);
        chk("sat_rate8", 32'(rate_out), 32'd8);

        // window aborted at cycle 10, spikes 5 apart
        en = 0; spike = 0;
        steps(2);
        en = 1;
        step();
        for (int k = 1; k <= 30; k++) begin
            spike = (k % 5 == 1);
            if (k == 10) en = 0;
            step();
            chk("abort_no_valid", 32'(rate_valid), 32'd0);
        end
`ifdef SPIKE_DEC_ISI_EN
        chk("isi_5", 32'(isi_out), 32'd5);
`endif

        // random traffic
        for (int k = 0; k < 700; k++) begin
            en    = ($urandom_range(0, 149) != 0);
            rdy   = ($urandom_range(0, 9) < 7);
            spike = ($urandom_range(0, 3) == 0);
            step();
        end

        // async reset mid-window with a held result
        en = 0; rdy = 1;
        steps(2);
        en = 1; rdy = 0;
        step();
        for (int k = 0; k < 24; k++) begin
            spike = $urandom_range(0, 1) == 1;
            step();
        end
        chk("pre_rst_valid", 32'(rate_valid), 32'd1);
        #2 rst = 1;
        #1 model_reset();
        check_all();
        chk("rst_valid0", 32'(rate_valid), 32'd0);
        chk("rst_busy0", 32'(busy), 32'd0);
        step();
        rst = 0; en = 0;
        step();
        chk("post_rst_idle", 32'(busy), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
